systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencer for the 9x9 output-stationary systolic multiply array. On start it pulses an array clear, then streams K operand columns of A and rows of B from external 1-cycle-latency operand memories. It applies the diagonal skew the array edges need: lane i is delayed i cycles and zero-padded. After the pipeline drains it pulses done, when every PE accumulator holds its final dot product.

Parameters:
N, 9, array dimension (lanes per edge)
DW, 4, operand width per lane
KW, 4, width of k_len / mem_addr (K max = 2^KW-1 = 15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a multiply; sampled only in IDLE
abort  in  1  synchronous cancel of an operation in progress
k_len  in  KW  inner dimension K, sampled with start; 0 = start ignored
mem_rd_en  out  1  operand memory read strobe
mem_addr  out  KW  operand index k
a_col  in  N*DW  A[.][k]; lane i = bits [i*DW +: DW]; valid the cycle after the read
b_row  in  N*DW  B[k][.]; same lane packing and timing
west_bus  out  N*DW  skewed feed to the west edge; lane i drives row i
north_bus  out  N*DW  skewed feed to the north edge; lane j drives column j
arr_rst  out  1  clear pulse to the array PEs
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset value of every output is 0: mem_rd_en, mem_addr, west_bus, north_bus, arr_rst, busy, done. After reset: state IDLE, all skew registers and counters are 0.
- States:
  - IDLE: wait for start.
  - CLEAR: 1 cycle.
  - FEED: K cycles.
  - DRAIN: count cycles.
  - DONE: 1 cycle.
- Transitions:
  - IDLE -> CLEAR on start=1 and k_len!=0. Latch K=k_len.
  - CLEAR -> FEED always.
  - FEED -> DRAIN after K cycles.
  - DRAIN -> DONE when the drain counter expires (see timing).
  - DONE -> IDLE.
- Timing, with start sampled in cycle S and F=S+2:
  - Cycle S+1 (CLEAR): arr_rst=1, busy=1.
  - Cycles F..F+K-1 (FEED): mem_rd_en=1, mem_addr=k for cycle F+k.
  - Cycles F+1..F+K: a_col/b_row are captured into the lane-0 stage. A capture-valid flag is mem_rd_en delayed 1 cycle. When the flag is 0, zeros are captured.
  - Skew: lane i of west_bus/north_bus is the captured lane-i data through i additional register stages. Every lane is registered.
  - Required result: west_bus lane i = A[i][k] exactly in cycle F+k+2+i, and 0 in every other cycle. north_bus is identical with B[k][i].
  - done=1 and busy=1 in cycle F+K+2N (F+K+18 for N=9). This is the cycle after PE(N-1,N-1) consumes its last operand pair.
  - busy=1 from S+1 through the done cycle inclusive; busy=0 otherwise.
- start while not IDLE is ignored and does not queue. A new start is accepted in the cycle after done.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, busy=0, mem_rd_en=0, all skew registers zeroed.
  - No done pulse. arr_rst is not pulsed.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- rst mid-operation overrides everything and has the same effect as a power-on reset. No done pulse.
- Drain counter: KW+3 bits wide is sufficient. The worst case is 2N+2 cycles with no wrap.
- mem_addr holds its last value in DRAIN/DONE and returns to 0 in IDLE.
- Data are passed through unmodified; no arithmetic is performed on operands.

Test Plan:
- Reset: hold rst 3 cycles mid-FEED (K=5) -> next cycle every output is 0, state IDLE, and no done pulse ever follows.
- Skew/timing, K=3, a_col lane i = k+1, b_row lane j = 2 at start cycle S:
  - arr_rst=1 only in cycle S+1.
  - mem_addr=0,1,2 in cycles S+2..S+4.
  - west lane 0 = 1,2,3 in cycles S+4..S+6; west lane 8 = 1,2,3 in cycles S+12..S+14.
  - Both buses are 0 elsewhere.
  - done=1 only in cycle S+23.
- End-to-end with the array attached, K=3, all A=1, all B=2 -> at done every PE result = 6.
- Maximum K=15, A=15, B=15 -> done at S+35; every result = 3375, with no truncation in the 16-bit accumulators.
- Protocol: start while busy is ignored. k_len=0 start leaves busy=0. Back-to-back starts issued in the cycle after done begin CLEAR on the next cycle, and the second run's data are unaffected by the first.
- abort asserted in the second DRAIN cycle (K=4) -> busy=0 the next cycle, buses 0, no done; a subsequent start with K=2 completes with done at S'+22.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN output-stationary systolic array. It clears the array, streams K
// operand columns/rows from 1-cycle memories with diagonal skew, then pulses done after the drain.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for start with a non-zero k_len
// S_CLEAR | one-cycle arr_rst pulse to the PE accumulators
// S_FEED  | K cycles of operand reads, mem_addr = k
// S_DRAIN | 2N cycles while the skewed wavefront finishes
// S_DONE  | one-cycle done pulse; busy still high
module systolic_seq_ctrl #(
    parameter int N  = 9,
    parameter int DW = 4,
    parameter int KW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [KW-1:0]   k_len,
    output logic            mem_rd_en,
    output logic [KW-1:0]   mem_addr,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic [N*DW-1:0] west_bus,
    output logic [N*DW-1:0] north_bus,
    output logic            arr_rst,
    output logic            busy,
    output logic            done
);

    localparam int CW = KW + 3;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(2 * N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k_last;
    logic [KW-1:0] k_cnt;
    logic [CW-1:0] drain_cnt;
    logic          cap_vld;
    logic          flush;

    assign flush = abort && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && (k_len != '0)) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (k_cnt == k_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    assign arr_rst   = (state == S_CLEAR);
    assign mem_rd_en = (state == S_FEED);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_addr  = k_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            k_last    <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
            cap_vld   <= 1'b0;
        end else begin
            if (state == S_IDLE && start && (k_len != '0)) begin
                k_last <= k_len - 1'b1;
            end

            // mem_addr holds through DRAIN/DONE and only returns to 0 on the way back to IDLE
            if (state_nxt == S_IDLE) begin
                k_cnt <= '0;
            end else if (state == S_FEED && state_nxt == S_FEED) begin
                k_cnt <= k_cnt + 1'b1;
            end

            if (state_nxt == S_IDLE) begin
                drain_cnt <= '0;
            end else if (state == S_FEED && state_nxt == S_DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            cap_vld <= mem_rd_en && !flush;
        end
    end

    // Lane i: one capture stage plus i skew stages, zero-padded whenever cap_vld is low
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_pipe [0:i];
        logic [DW-1:0] b_pipe [0:i];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                for (int j = 0; j <= i; j++) begin
                    a_pipe[j] <= '0;
                    b_pipe[j] <= '0;
                end
            end else begin
                a_pipe[0] <= cap_vld ? a_col[i*DW +: DW] : '0;
                b_pipe[0] <= cap_vld ? b_row[i*DW +: DW] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_pipe[j] <= a_pipe[j-1];
                    b_pipe[j] <= b_pipe[j-1];
                end
            end
        end

        assign west_bus[i*DW +: DW]  = a_pipe[i];
        assign north_bus[i*DW +: DW] = b_pipe[i];
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: operand memory model, behavioural PE mesh,
// and hand-computed cycle offsets for skew, done timing, abort and reset.
module tb_systolic_seq_ctrl;

    localparam int N  = 9;
    localparam int DW = 4;
    localparam int KW = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [KW-1:0]   k_len;
    logic            mem_rd_en;
    logic [KW-1:0]   mem_addr;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic [N*DW-1:0] west_bus;
    logic [N*DW-1:0] north_bus;
    logic            arr_rst;
    logic            busy;
    logic            done;

    systolic_seq_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .k_len     (k_len),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .a_col     (a_col),
        .b_row     (b_row),
        .west_bus  (west_bus),
        .north_bus (north_bus),
        .arr_rst   (arr_rst),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int s_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: 1-cycle read latency; all-ones when not read so zero padding is visible
    logic [N*DW-1:0] a_mem [16];
    logic [N*DW-1:0] b_mem [16];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            a_col <= a_mem[mem_addr];
            b_row <= b_mem[mem_addr];
        end else begin
            a_col <= '1;
            b_row <= '1;
        end
    end

    // Behavioural output-stationary mesh: A flows east, B flows south
    logic [DW-1:0] m_a   [N][N];
    logic [DW-1:0] m_b   [N][N];
    int            m_acc [N][N];
    int            ai, bi;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ai = int'(west_bus[i*DW +: DW]);
                else        ai = int'(m_a[i][j-1]);
                if (i == 0) bi = int'(north_bus[j*DW +: DW]);
                else        bi = int'(m_b[i-1][j]);
                m_a[i][j] <= DW'(ai);
                m_b[i][j] <= DW'(bi);
                if (rst || arr_rst) m_acc[i][j] <= 0;
                else                m_acc[i][j] <= m_acc[i][j] + ai * bi;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_const(input int av, input int bv);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[k][i*DW +: DW] = DW'(av);
                b_mem[k][i*DW +: DW] = DW'(bv);
            end
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                a_mem[k][i*DW +: DW] = DW'(k + 1);
                b_mem[k][i*DW +: DW] = DW'(2);
            end
        end
    endtask

    task automatic do_start(input int k);
        start = 1'b1;
        k_len = KW'(k);
        s_cyc = cyc;
        step();
        start = 1'b0;
        k_len = '0;
    endtask

    task automatic wait_done(output int off);
        off = -1;
        for (int t = 0; t < 80; t++) begin
            if (done) begin
                off = cyc - s_cyc;
                break;
            end
            step();
        end
        chk("done_seen", done, 1);
    endtask

    task automatic watch(input int n, output int dn, output int bz);
        dn = 0;
        bz = 0;
        for (int t = 0; t < n; t++) begin
            dn += int'(done);
            bz += int'(busy);
            step();
        end
    endtask

    task automatic chk_array(input string tag, input int expv);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (m_acc[i][j] != expv) bad++;
        chk({tag, "_bad_pes"}, bad, 0);
        chk({tag, "_pe88"}, m_acc[N-1][N-1], expv);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_west"}, west_bus, 0);
        chk({tag, "_north"}, north_bus, 0);
        chk({tag, "_arr_rst"}, arr_rst, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    logic [N*DW-1:0] exp_w, exp_n;
    int              exp_addr;
    int              off, dn, bz;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        load_const(0, 0);
        step();
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Skew and timing, K=3, A lane i = k+1, B = 2
        load_ramp();
        do_start(3);
        for (int c = 1; c <= 25; c++) begin
            exp_w = '0;
            exp_n = '0;
            for (int i = 0; i < N; i++) begin
                if (c >= 4 + i && c <= 6 + i) begin
                    exp_w[i*DW +: DW] = DW'(c - 3 - i);
                    exp_n[i*DW +: DW] = DW'(2);
                end
            end
            if (c >= 2 && c <= 4)       exp_addr = c - 2;
            else if (c >= 5 && c <= 23) exp_addr = 2;
            else                        exp_addr = 0;
            chk($sformatf("west_c%0d", c), west_bus, exp_w);
            chk($sformatf("north_c%0d", c), north_bus, exp_n);
            chk($sformatf("addr_c%0d", c), mem_addr, exp_addr);
            chk($sformatf("rd_en_c%0d", c), mem_rd_en, (c >= 2 && c <= 4));
            chk($sformatf("arr_rst_c%0d", c), arr_rst, (c == 1));
            chk($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 23));
            chk($sformatf("done_c%0d", c), done, (c == 23));
            if (c == 23) chk_array("ramp", 12);
            step();
        end

        // End-to-end K=3, A=1, B=2, with an ignored start mid-run
        load_const(1, 2);
        do_start(3);
        repeat (4) step();
        start = 1'b1;
        k_len = 4'd7;
        step();
        start = 1'b0;
        k_len = '0;
        wait_done(off);
        chk("e2e_done_off", off, 23);
        chk_array("e2e", 6);
        step();
        chk("ignored_start_busy1", busy, 0);
        step();
        chk("ignored_start_busy2", busy, 0);

        // k_len = 0 start is ignored
        do_start(0);
        chk("k0_busy", busy, 0);
        chk("k0_arr_rst", arr_rst, 0);
        step();
        chk("k0_busy2", busy, 0);

        // Maximum K with maximum operands
        load_const(15, 15);
        do_start(15);
        wait_done(off);
        chk("max_done_off", off, 35);
        chk_array("max", 3375);

        // Back-to-back start in the cycle after done
        load_const(1, 5);
        step();
        chk("b2b_idle_busy", busy, 0);
        do_start(2);
        chk("b2b_arr_rst", arr_rst, 1);
        chk("b2b_busy", busy, 1);
        wait_done(off);
        chk("b2b_done_off", off, 22);
        chk_array("b2b", 10);
        step();

        // Abort in the second DRAIN cycle
        load_const(7, 7);
        do_start(4);
        repeat (6) step();
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_west", west_bus, 0);
        chk("abort_north", north_bus, 0);
        chk("abort_done", done, 0);
        watch(30, dn, bz);
        chk("abort_no_done", dn, 0);
        chk("abort_no_busy", bz, 0);
        load_const(2, 3);
        do_start(2);
        wait_done(off);
        chk("post_abort_done_off", off, 22);
        chk_array("post_abort", 12);
        step();

        // Reset mid-FEED
        do_start(5);
        step();
        step();
        chk("rst_pre_rd_en", mem_rd_en, 1);
        rst = 1'b1;
        step();
        chk_idle_outputs("mid_rst");
        step();
        step();
        rst = 1'b0;
        watch(40, dn, bz);
        chk("mid_rst_no_done", dn, 0);
        chk("mid_rst_no_busy", bz, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
